// File: rtl/dport_monitor_if.sv
// Bundle of the data-port capture, readback and status signals between the
// system under test (master) and dport_monitor (slave).
interface dport_monitor_if #(
    parameter int WIDTH      = 8,
    parameter int DEPTH      = 256,
    parameter int MAX_CYCLES = 100
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(MAX_CYCLES + 1);

    logic [WIDTH-1:0] dport_out;
    logic             dport_write;
    logic             done;
    logic [AW-1:0]    rd_addr;
    logic [WIDTH-1:0] rd_data;
    logic [AW:0]      wr_count;
    logic             overflow;
    logic [CW-1:0]    cycles;
    logic             finished;
    logic             timed_out;

    modport master (
        output dport_out, dport_write, done, rd_addr,
        input  rd_data, wr_count, overflow, cycles, finished, timed_out
    );

    modport slave (
        input  dport_out, dport_write, done, rd_addr,
        output rd_data, wr_count, overflow, cycles, finished, timed_out
    );
endinterface

// File: rtl/dport_monitor.sv
// Capture monitor for the system data port: buffers dport_write beats and
// tracks run/drain/finish/timeout around the system done signal.
module dport_monitor #(
    parameter int WIDTH        = 8,
    parameter int DEPTH        = 256,
    parameter int WRAP         = 0,
    parameter int MAX_CYCLES   = 100,
    parameter int DRAIN_CYCLES = 2
) (
    input  logic            clk,
    input  logic            rst,
    dport_monitor_if.slave  bus
);
    localparam int AW  = $clog2(DEPTH);
    localparam int AW1 = AW + 1;
    localparam int CW  = $clog2(MAX_CYCLES + 1);
    localparam int CW1 = CW + 1;
    localparam int DCW = (DRAIN_CYCLES > 0) ? $clog2(DRAIN_CYCLES + 1) : 1;

    typedef enum logic [1:0] {RUN, DRAIN, FINISHED, TIMEOUT} state_t;

    state_t           state_q, state_d;
    logic [AW-1:0]    wp_q, wp_d;
    logic [AW:0]      wr_count_q, wr_count_d;
    logic             overflow_q, overflow_d;
    logic [CW-1:0]    cycles_q, cycles_d;
    logic [DCW-1:0]   drain_q, drain_d;
    logic [WIDTH-1:0] rd_data_q, rd_data_d;
    logic             finished_q, finished_d;
    logic             timed_out_q, timed_out_d;

    logic [WIDTH-1:0] mem [DEPTH];
    logic             mem_we;
    logic             active;
    logic             full;
    logic             at_limit;
    logic [AW-1:0]    rd_phys;

    always_comb begin
        state_d     = state_q;
        wp_d        = wp_q;
        wr_count_d  = wr_count_q;
        overflow_d  = overflow_q;
        cycles_d    = cycles_q;
        drain_d     = drain_q;
        mem_we      = 1'b0;

        active   = (state_q == RUN) || (state_q == DRAIN);
        full     = (wr_count_q == AW1'(DEPTH));
        // >= also covers DRAIN entered on the limit edge, keeping cycles capped
        at_limit = (({1'b0, cycles_q} + CW1'(1)) >= CW1'(MAX_CYCLES));

        if (active && bus.dport_write) begin
            if (!full) begin
                mem_we     = 1'b1;
                wp_d       = wp_q + AW'(1);
                wr_count_d = wr_count_q + AW1'(1);
            end else begin
                overflow_d = 1'b1;
                if (WRAP != 0) begin
                    mem_we = 1'b1;
                    wp_d   = wp_q + AW'(1);
                end
            end
        end

        if (active) begin
            cycles_d = at_limit ? CW'(MAX_CYCLES) : cycles_q + CW'(1);
        end

        case (state_q)
            RUN: begin
                // done outranks a timeout landing on the same edge
                if (bus.done) begin
                    if (DRAIN_CYCLES == 0) begin
                        state_d = FINISHED;
                    end else begin
                        state_d = DRAIN;
                        drain_d = DCW'(DRAIN_CYCLES);
                    end
                end else if (at_limit) begin
                    state_d = TIMEOUT;
                end
            end
            DRAIN: begin
                drain_d = drain_q - DCW'(1);
                if (drain_q == DCW'(1)) begin
                    state_d = FINISHED;
                end else if (at_limit) begin
                    state_d = TIMEOUT;
                end
            end
            default: ;
        endcase

        // Once full in circular mode the oldest entry sits at the write pointer
        rd_phys   = ((WRAP != 0) && full) ? (wp_q + bus.rd_addr) : bus.rd_addr;
        rd_data_d = ({1'b0, bus.rd_addr} < wr_count_q) ? mem[rd_phys] : '0;

        finished_d  = (state_d == FINISHED);
        timed_out_d = (state_d == TIMEOUT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= RUN;
            wp_q        <= '0;
            wr_count_q  <= '0;
            overflow_q  <= 1'b0;
            cycles_q    <= '0;
            drain_q     <= '0;
            rd_data_q   <= '0;
            finished_q  <= 1'b0;
            timed_out_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            wp_q        <= wp_d;
            wr_count_q  <= wr_count_d;
            overflow_q  <= overflow_d;
            cycles_q    <= cycles_d;
            drain_q     <= drain_d;
            rd_data_q   <= rd_data_d;
            finished_q  <= finished_d;
            timed_out_q <= timed_out_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && mem_we) begin
            mem[wp_q] <= bus.dport_out;
        end
    end

    assign bus.rd_data   = rd_data_q;
    assign bus.wr_count  = wr_count_q;
    assign bus.overflow  = overflow_q;
    assign bus.cycles    = cycles_q;
    assign bus.finished  = finished_q;
    assign bus.timed_out = timed_out_q;
endmodule

// File: tb/tb_dport_monitor.sv
// Scoreboard bench for dport_monitor: three parameterisations share one stimulus
// thread; expectations are queued with a due cycle and checked by a monitor.
module tb_dport_monitor;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int unsigned cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dport_monitor_if #(.WIDTH(8), .DEPTH(256), .MAX_CYCLES(100)) ifa ();
    dport_monitor_if #(.WIDTH(8), .DEPTH(4),   .MAX_CYCLES(100)) ifb ();
    dport_monitor_if #(.WIDTH(8), .DEPTH(4),   .MAX_CYCLES(100)) ifc ();

    dport_monitor #(.WIDTH(8), .DEPTH(256), .WRAP(0), .MAX_CYCLES(100), .DRAIN_CYCLES(2))
        dut_a (.clk(clk), .rst(rst), .bus(ifa));
    dport_monitor #(.WIDTH(8), .DEPTH(4), .WRAP(0), .MAX_CYCLES(100), .DRAIN_CYCLES(2))
        dut_b (.clk(clk), .rst(rst), .bus(ifb));
    dport_monitor #(.WIDTH(8), .DEPTH(4), .WRAP(1), .MAX_CYCLES(100), .DRAIN_CYCLES(2))
        dut_c (.clk(clk), .rst(rst), .bus(ifc));

    localparam int F_RD = 0, F_CNT = 1, F_OVF = 2, F_CYC = 3, F_FIN = 4, F_TO = 5;

    typedef struct {
        int unsigned due;
        int          inst;
        int          fld;
        logic [31:0] exp;
        string       name;
    } chk_t;

    chk_t sbq[$];
    int n_pass  = 0;
    int n_total = 0;

    function automatic logic [31:0] actual(input int inst, input int fld);
        logic [31:0] v;
        v = '0;
        case (inst)
            0: case (fld)
                F_RD:  v = 32'(ifa.rd_data);
                F_CNT: v = 32'(ifa.wr_count);
                F_OVF: v = 32'(ifa.overflow);
                F_CYC: v = 32'(ifa.cycles);
                F_FIN: v = 32'(ifa.finished);
                default: v = 32'(ifa.timed_out);
            endcase
            1: case (fld)
                F_RD:  v = 32'(ifb.rd_data);
                F_CNT: v = 32'(ifb.wr_count);
                F_OVF: v = 32'(ifb.overflow);
                F_CYC: v = 32'(ifb.cycles);
                F_FIN: v = 32'(ifb.finished);
                default: v = 32'(ifb.timed_out);
            endcase
            default: case (fld)
                F_RD:  v = 32'(ifc.rd_data);
                F_CNT: v = 32'(ifc.wr_count);
                F_OVF: v = 32'(ifc.overflow);
                F_CYC: v = 32'(ifc.cycles);
                F_FIN: v = 32'(ifc.finished);
                default: v = 32'(ifc.timed_out);
            endcase
        endcase
        return v;
    endfunction

    // Monitor: after each edge, retire every expectation that has come due
    initial begin
        chk_t c;
        logic [31:0] a;
        forever begin
            @(posedge clk);
            #1;
            while (sbq.size() > 0 && sbq[0].due <= cyc) begin
                c = sbq.pop_front();
                a = actual(c.inst, c.fld);
                n_total++;
                if (a === c.exp) n_pass++;
                else $display("FAIL %s: got 0x%0h expected 0x%0h", c.name, a, c.exp);
            end
        end
    end

    // Expectation on the value visible just after the next rising edge
    task automatic expect_nx(input int inst, input int fld, input logic [31:0] exp,
                             input string name);
        chk_t c;
        c.due  = cyc + 1;
        c.inst = inst;
        c.fld  = fld;
        c.exp  = exp;
        c.name = name;
        sbq.push_back(c);
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic drive(input logic w, input logic [7:0] d, input logic dn);
        ifa.dport_write = w; ifb.dport_write = w; ifc.dport_write = w;
        ifa.dport_out   = d; ifb.dport_out   = d; ifc.dport_out   = d;
        ifa.done        = dn; ifb.done       = dn; ifc.done       = dn;
    endtask

    task automatic setrd(input int a);
        ifa.rd_addr = 8'(a);
        ifb.rd_addr = 2'(a);
        ifc.rd_addr = 2'(a);
    endtask

    task automatic reset_pulse();
        rst = 1'b1;
        drive(1'b0, 8'h00, 1'b0);
        step();
        rst = 1'b0;
    endtask

    initial begin
        drive(1'b0, 8'h00, 1'b0);
        setrd(0);
        step();
        step();

        // Reset values
        expect_nx(0, F_RD,  0, "reset_rd_data");
        expect_nx(0, F_CNT, 0, "reset_wr_count");
        expect_nx(0, F_OVF, 0, "reset_overflow");
        expect_nx(0, F_CYC, 0, "reset_cycles");
        expect_nx(0, F_FIN, 0, "reset_finished");
        expect_nx(0, F_TO,  0, "reset_timed_out");
        step();
        rst = 1'b0;

        // Three beats, done on edge 10, drain of 2 -> finished after edge 12
        for (int e = 1; e <= 12; e++) begin
            drive((e >= 2 && e <= 4), (e == 2) ? 8'h11 : (e == 3) ? 8'h22 : 8'h33, (e == 10));
            if (e == 11) expect_nx(0, F_FIN, 0, "t1_not_yet_finished");
            if (e == 12) begin
                expect_nx(0, F_FIN, 1, "t1_finished");
                expect_nx(0, F_CYC, 12, "t1_cycles");
            end
            step();
        end
        drive(1'b1, 8'h77, 1'b0);
        setrd(0); expect_nx(0, F_RD, 32'h11, "t1_rd0"); expect_nx(0, F_CNT, 3, "t1_wr_count"); step();
        setrd(1); expect_nx(0, F_RD, 32'h22, "t1_rd1"); step();
        setrd(2); expect_nx(0, F_RD, 32'h33, "t1_rd2"); step();
        setrd(3); expect_nx(0, F_RD, 32'h00, "t1_rd3_empty");
        expect_nx(0, F_CNT, 3, "t1_no_capture_finished");
        expect_nx(0, F_OVF, 0, "t1_overflow");
        expect_nx(0, F_TO,  0, "t1_timed_out");
        step();

        // DEPTH=4: six beats, stop-when-full (b) and circular (c)
        reset_pulse();
        for (int i = 1; i <= 6; i++) begin
            drive(1'b1, 8'(i), 1'b0);
            if (i == 4) begin
                expect_nx(1, F_CNT, 4, "t2_count_at_full");
                expect_nx(1, F_OVF, 0, "t2_no_ovf_at_full");
            end
            step();
        end
        drive(1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 4; i++) begin
            setrd(i);
            expect_nx(1, F_RD, 32'(i + 1), $sformatf("t2_rd%0d", i));
            expect_nx(2, F_RD, 32'(i + 3), $sformatf("t3_rd%0d", i));
            step();
        end
        expect_nx(1, F_CNT, 4, "t2_wr_count");
        expect_nx(1, F_OVF, 1, "t2_overflow");
        expect_nx(2, F_CNT, 4, "t3_wr_count");
        expect_nx(2, F_OVF, 1, "t3_overflow");
        step();

        // Timeout with no done
        reset_pulse();
        setrd(0);
        for (int e = 1; e <= 100; e++) begin
            if (e == 99) expect_nx(0, F_TO, 0, "t4_not_yet_timed_out");
            if (e == 100) begin
                expect_nx(0, F_TO,  1, "t4_timed_out");
                expect_nx(0, F_CYC, 100, "t4_cycles_at_timeout");
            end
            step();
        end
        drive(1'b1, 8'h5A, 1'b0);
        step(); step(); step();
        drive(1'b0, 8'h00, 1'b0);
        expect_nx(0, F_CNT, 0, "t4_no_capture_after");
        expect_nx(0, F_CYC, 100, "t4_cycles_hold");
        expect_nx(0, F_FIN, 0, "t4_finished_low");
        expect_nx(0, F_RD,  0, "t4_rd_empty");
        step();

        // done with a beat, two drain beats, a late beat dropped
        reset_pulse();
        drive(1'b1, 8'hA1, 1'b1); step();
        drive(1'b1, 8'hA2, 1'b0); expect_nx(0, F_FIN, 0, "t5_draining"); step();
        drive(1'b1, 8'hA3, 1'b0); expect_nx(0, F_FIN, 1, "t5_finished"); step();
        drive(1'b1, 8'hA4, 1'b0); step();
        drive(1'b0, 8'h00, 1'b0);
        setrd(0); expect_nx(0, F_RD, 32'hA1, "t5_rd0"); expect_nx(0, F_CNT, 3, "t5_wr_count"); step();
        setrd(1); expect_nx(0, F_RD, 32'hA2, "t5_rd1"); step();
        setrd(2); expect_nx(0, F_RD, 32'hA3, "t5_rd2"); expect_nx(0, F_CYC, 3, "t5_cycles"); step();
        setrd(3); expect_nx(0, F_RD, 32'h00, "t5_rd3_dropped"); step();

        // done on the edge that reaches MAX_CYCLES enters DRAIN, not TIMEOUT
        reset_pulse();
        for (int e = 1; e <= 100; e++) begin
            drive(1'b0, 8'h00, (e == 100));
            if (e == 100) begin
                expect_nx(0, F_TO,  0, "t6_done_beats_timeout");
                expect_nx(0, F_FIN, 0, "t6_in_drain");
                expect_nx(0, F_CYC, 100, "t6_cycles_max");
            end
            step();
        end
        drive(1'b0, 8'h00, 1'b0);
        expect_nx(0, F_TO,  1, "t6_drain_timeout");
        expect_nx(0, F_CYC, 100, "t6_cycles_capped");
        step();

        // Mid-run reset alongside a beat and done
        reset_pulse();
        setrd(0);
        for (int i = 1; i <= 5; i++) begin
            drive(1'b1, 8'(8'h50 + i), 1'b0);
            if (i == 5) expect_nx(0, F_CNT, 5, "t7_pre_reset_count");
            step();
        end
        rst = 1'b1;
        drive(1'b1, 8'hEE, 1'b1);
        expect_nx(0, F_CNT, 0, "t7_rst_wr_count");
        expect_nx(0, F_CYC, 0, "t7_rst_cycles");
        expect_nx(0, F_RD,  0, "t7_rst_rd_data");
        expect_nx(0, F_OVF, 0, "t7_rst_overflow");
        expect_nx(0, F_FIN, 0, "t7_rst_finished");
        expect_nx(0, F_TO,  0, "t7_rst_timed_out");
        step();
        rst = 1'b0;
        drive(1'b1, 8'h61, 1'b0);
        expect_nx(0, F_CNT, 1, "t7_post_count");
        step();
        drive(1'b0, 8'h00, 1'b0);
        setrd(0); expect_nx(0, F_RD, 32'h61, "t7_rd0"); step();
        setrd(1); expect_nx(0, F_RD, 32'h00, "t7_rd1_empty"); step();

        // Drain the scoreboard within a bounded number of cycles
        for (int k = 0; k < 10 && sbq.size() > 0; k++) step();
        if (sbq.size() > 0) begin
            n_total++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0 pending", sbq.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
